mac_sequencer: RTL and testbench

Control stage directly upstream of `mac` in the perceptron datapath. It accepts a byte stream holding a bias plus N weight/input pairs and stores it in a register file. It then drives one `mac` instance term by term, feeding the running sum back through `previous_out` while honouring the MAC's fixed pipeline latency. It presents the final 8-bit neuron sum and a step-activation `fire` flag.

---
 rtl/perceptron_pkg.sv | 19 +
 rtl/mac_sequencer_if.sv | 24 ++
 rtl/mac_seq_regfile.sv | 34 +++
 rtl/mac_sequencer.sv | 137 +++++++++++++
 tb/tb_mac_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/perceptron_pkg.sv
// Shared perceptron definitions: datapath width, default MAC latency, sequencer
// state encoding and a signed-positive helper used for the step activation.
package perceptron_pkg;

  localparam int DATA_W          = 8;
  localparam int MAC_LAT_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } seq_state_t;

  function automatic logic is_positive(input logic [DATA_W-1:0] v);
    return (v != '0) && !v[DATA_W-1];
  endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Load/start/result bundle of mac_sequencer. A load byte transfers on a clock
// edge where load_valid && load_ready; result/fire are valid while result_valid.
interface mac_sequencer_if;
  import perceptron_pkg::*;

  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              start;
  logic              busy;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              fire;

  modport master (
    output load_valid, load_data, start,
    input  load_ready, busy, result, result_valid, fire
  );

  modport slave (
    input  load_valid, load_data, start,
    output load_ready, busy, result, result_valid, fire
  );
endinterface

// File: rtl/mac_seq_regfile.sv
// Byte-addressed store for bias, w0, x0, w1, x1, ... written during load;
// combinational read of the bias and the w/x pair selected by k_i.
module mac_seq_regfile
  import perceptron_pkg::*;
#(
  parameter  int N_INPUTS = 4,
  localparam int NB       = 2 * N_INPUTS + 1,
  localparam int AW       = $clog2(NB),
  localparam int KW       = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [KW-1:0]     k_i,
  output logic [DATA_W-1:0] bias_o,
  output logic [DATA_W-1:0] w_o,
  output logic [DATA_W-1:0] x_o
);
  logic [DATA_W-1:0] mem_q [NB];
  logic [AW-1:0]     w_idx;
  logic [AW-1:0]     x_idx;

  // Contents are deliberately unreset; a fresh load always precedes use.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign w_idx  = AW'({k_i, 1'b1});
  assign x_idx  = w_idx + AW'(1);
  assign bias_o = mem_q[0];
  assign w_o    = mem_q[w_idx];
  assign x_o    = mem_q[x_idx];
endmodule

// File: rtl/mac_sequencer.sv
// Loads bias + N weight/input pairs, then steps an external mac term by term.
// Build option MAC_SEQ_RELU_EN clamps non-positive sums to zero on result.
module mac_sequencer
  import perceptron_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int MAC_LAT  = MAC_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  mac_sequencer_if.slave    bus,
  output logic [DATA_W-1:0] x_o,
  output logic [DATA_W-1:0] w_o,
  output logic [DATA_W-1:0] prev_o,
  input  logic [DATA_W-1:0] mac_out_i,
  output seq_state_t        dbg_state_o
);
  localparam int NB = 2 * N_INPUTS + 1;
  localparam int AW = $clog2(NB);
  localparam int KW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int CW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [AW-1:0] LAST_IDX  = AW'(NB - 1);
  localparam logic [KW-1:0] LAST_K    = KW'(N_INPUTS - 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAC_LAT - 1);

  seq_state_t        state_q;
  logic [AW-1:0]     idx_q;
  logic              loaded_q;
  logic              load_ready_q;
  logic [KW-1:0]     k_q;
  logic [CW-1:0]     wait_q;
  logic [DATA_W-1:0] acc_q, x_q, w_q, result_q;
  logic              result_valid_q, fire_q;

  logic              we;
  logic [KW-1:0]     rd_k;
  logic [DATA_W-1:0] rd_bias, rd_w, rd_x, result_d;
  logic              fire_d;

  assign we = (state_q == IDLE) && bus.load_valid && load_ready_q;
  // Outputs are registered, so the pair for the next ISSUE is read during WAIT.
  assign rd_k = (state_q == WAIT) ? k_q + KW'(1) : k_q;

  mac_seq_regfile #(.N_INPUTS(N_INPUTS)) u_regfile (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (idx_q),
    .wdata_i (bus.load_data),
    .k_i     (rd_k),
    .bias_o  (rd_bias),
    .w_o     (rd_w),
    .x_o     (rd_x)
  );

  assign fire_d = is_positive(mac_out_i);
`ifdef MAC_SEQ_RELU_EN
  assign result_d = fire_d ? mac_out_i : '0;
`else
  assign result_d = mac_out_i;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      loaded_q       <= 1'b0;
      load_ready_q   <= 1'b1;
      k_q            <= '0;
      wait_q         <= '0;
      acc_q          <= '0;
      x_q            <= '0;
      w_q            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      fire_q         <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (we) begin
            idx_q <= idx_q + AW'(1);
            if (idx_q == LAST_IDX) begin
              loaded_q     <= 1'b1;
              load_ready_q <= 1'b0;
            end
          end else if (bus.start && loaded_q) begin
            state_q <= ISSUE;
            k_q     <= '0;
            acc_q   <= rd_bias;
            x_q     <= rd_x;
            w_q     <= rd_w;
          end
        end
        ISSUE: begin
          wait_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (wait_q == LAST_WAIT) begin
            acc_q <= mac_out_i;
            if (k_q == LAST_K) begin
              state_q        <= DONE;
              result_q       <= result_d;
              fire_q         <= fire_d;
              result_valid_q <= 1'b1;
            end else begin
              state_q <= ISSUE;
              k_q     <= k_q + KW'(1);
              x_q     <= rd_x;
              w_q     <= rd_w;
            end
          end else begin
            wait_q <= wait_q + CW'(1);
          end
        end
        DONE: begin
          state_q      <= IDLE;
          loaded_q     <= 1'b0;
          idx_q        <= '0;
          k_q          <= '0;
          load_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.load_ready   = load_ready_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.fire         = fire_q;
  assign x_o              = x_q;
  assign w_o              = w_q;
  assign prev_o           = acc_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer with a behavioural fixed-latency mac beside it and a
// sum-of-products reference model computed from the loaded bytes.
module tb_mac_sequencer;
  import perceptron_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int NBY = 2 * N + 1;
  localparam int EXP_LAT = N * (LAT + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] x_o, w_o, prev_o, mac_out;
  seq_state_t dbg_state;
  mac_sequencer_if bus ();

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] bias_v;
  logic [7:0] w_v [N];
  logic [7:0] x_v [N];

  always #5 clk = ~clk;

  mac_sequencer #(.N_INPUTS(N), .MAC_LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .x_o         (x_o),
    .w_o         (w_o),
    .prev_o      (prev_o),
    .mac_out_i   (mac_out),
    .dbg_state_o (dbg_state)
  );

  // Behavioural mac: out = previous_out + x*w, visible LAT cycles later, unreset.
  logic [7:0] mac_pipe [LAT];
  always @(posedge clk) begin
    mac_pipe[0] <= 8'(prev_o + x_o * w_o);
    for (int i = 1; i < LAT; i++) mac_pipe[i] <= mac_pipe[i-1];
  end
  assign mac_out = mac_pipe[LAT-1];

  function automatic logic [7:0] model_sum();
    int s = int'(bias_v);
    for (int k = 0; k < N; k++) s += int'(w_v[k]) * int'(x_v[k]);
    return 8'(s % 256);
  endfunction

  function automatic logic model_fire(input logic [7:0] s);
    return $signed(s) > 0;
  endfunction

  function automatic logic [7:0] model_result(input logic [7:0] s);
`ifdef MAC_SEQ_RELU_EN
    return ($signed(s) > 0) ? s : 8'd0;
`else
    return s;
`endif
  endfunction

  function automatic logic [7:0] byte_at(input int i);
    if (i == 0) return bias_v;
    return ((i % 2) == 1) ? w_v[(i-1)/2] : x_v[(i-2)/2];
  endfunction

  task automatic set_random();
    bias_v = 8'($urandom_range(0, 255));
    for (int k = 0; k < N; k++) begin
      w_v[k] = 8'($urandom_range(0, 255));
      x_v[k] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    int guard = 0;
    bus.load_valid = 1'b1;
    bus.load_data  = b;
    while (!done && guard < 50) begin
      done = (bus.load_ready === 1'b1);
      @(posedge clk); #1;
      guard++;
    end
    bus.load_valid = 1'b0;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL load_handshake: load_ready never high, byte %0h", b);
    end
  endtask

  task automatic load_range(input int from, input int to, input bit gaps);
    for (int i = from; i <= to; i++) begin
      send_byte(byte_at(i));
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Starts a compute and checks first issue, latency, result, fire and hold.
  task automatic run_and_check(input string name, input bit hammer);
    logic [7:0] s, exp_r;
    logic exp_f;
    int n = 0;
    bit seen = 0;
    s = model_sum();
    exp_r = model_result(s);
    exp_f = model_fire(s);
    do_start();
    n_tests++;
    if (bus.busy !== 1'b1 || prev_o !== bias_v || x_o !== x_v[0] || w_o !== w_v[0]) begin
      n_fail++;
      $display("FAIL %s_issue0: busy=%b prev=%0h x=%0h w=%0h expected busy=1 prev=%0h x=%0h w=%0h",
               name, bus.busy, prev_o, x_o, w_o, bias_v, x_v[0], w_v[0]);
    end
    while (!seen && n < 100) begin
      if (hammer) begin
        bus.load_valid = 1'b1;
        bus.load_data  = 8'($urandom_range(0, 255));
      end
      @(posedge clk); #1;
      n++;
      if (bus.result_valid === 1'b1) begin
        seen = 1;
        bus.load_valid = 1'b0;
      end else if (hammer) begin
        n_tests++;
        if (bus.load_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_busy_ready: load_ready=%b expected 0 at cycle %0d", name, bus.load_ready, n);
        end
      end
    end
    bus.load_valid = 1'b0;
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: no result_valid within 100 cycles", name);
      return;
    end
    n_tests++;
    if (n !== EXP_LAT) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles expected %0d", name, n + 1, EXP_LAT + 1);
    end
    n_tests++;
    if (bus.result !== exp_r || bus.fire !== exp_f) begin
      n_fail++;
      $display("FAIL %s_result: result=%0h fire=%b expected result=%0h fire=%b",
               name, bus.result, bus.fire, exp_r, exp_f);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.result_valid !== 1'b0 || bus.result !== exp_r || bus.fire !== exp_f ||
        bus.busy !== 1'b0 || bus.load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_after: rv=%b result=%0h fire=%b busy=%b ready=%b expected rv=0 result=%0h fire=%b busy=0 ready=1",
               name, bus.result_valid, bus.result, bus.fire, bus.busy, bus.load_ready, exp_r, exp_f);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.load_ready !== 1'b1 || bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b busy=%b rv=%b expected 1 0 0", bus.load_ready, bus.busy, bus.result_valid);
    end
    n_tests++;
    if (x_o !== 8'd0 || w_o !== 8'd0 || prev_o !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mac_drive: x=%0h w=%0h prev=%0h expected 0 0 0", x_o, w_o, prev_o);
    end
    n_tests++;
    if (bus.result !== 8'd0 || bus.fire !== 1'b0 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_result: result=%0h fire=%b state=%0d expected 0 0 %0d", bus.result, bus.fire, dbg_state, IDLE);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] wl [N] = '{8'd2, 8'd3, 8'd0, 8'd1};
    logic [7:0] xl [N] = '{8'd5, 8'd1, 8'd9, 8'd4};
    bias_v = 8'd1;
    for (int k = 0; k < N; k++) begin w_v[k] = wl[k]; x_v[k] = xl[k]; end
    n_tests++;
    if (model_sum() !== 8'd18) begin
      n_fail++;
      $display("FAIL basic_model: got %0d expected 18", model_sum());
    end
    load_range(0, NBY - 1, 0);
    run_and_check("basic", 0);
  endtask

  task automatic test_wrap();
    bias_v = 8'd0;
    for (int k = 0; k < N; k++) begin w_v[k] = 8'd0; x_v[k] = 8'd0; end
    w_v[0] = 8'd16; x_v[0] = 8'd16;
    load_range(0, NBY - 1, 1);
    run_and_check("wrap", 0);
  endtask

  task automatic test_negative();
    bias_v = 8'h80;
    for (int k = 0; k < N; k++) begin w_v[k] = 8'd0; x_v[k] = 8'd0; end
    load_range(0, NBY - 1, 0);
    run_and_check("negative", 0);
  endtask

  task automatic test_early_start();
    set_random();
    load_range(0, 3, 0);
    do_start();
    repeat (3) begin
      n_tests++;
      if (bus.busy !== 1'b0 || bus.load_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL early_start: busy=%b ready=%b expected 0 1", bus.busy, bus.load_ready);
      end
      @(posedge clk); #1;
    end
    load_range(4, NBY - 1, 1);
    run_and_check("early_start", 0);
  endtask

  task automatic test_load_during_compute();
    set_random();
    load_range(0, NBY - 1, 0);
    run_and_check("load_busy", 1);
  endtask

  task automatic test_reset_mid_wait();
    bit rv_seen = 0;
    set_random();
    load_range(0, NBY - 1, 0);
    do_start();
    repeat (2 * (LAT + 1) + 1) begin @(posedge clk); #1; end
    n_tests++;
    if (dbg_state !== WAIT) begin
      n_fail++;
      $display("FAIL midreset_state: state=%0d expected %0d", dbg_state, WAIT);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.load_ready !== 1'b1 || prev_o !== 8'd0 || bus.result !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_regs: busy=%b ready=%b prev=%0h result=%0h expected 0 1 0 0",
               bus.busy, bus.load_ready, prev_o, bus.result);
    end
    for (int i = 0; i < EXP_LAT + 4; i++) begin
      if (bus.result_valid === 1'b1) rv_seen = 1;
      @(posedge clk); #1;
    end
    n_tests++;
    if (rv_seen) begin
      n_fail++;
      $display("FAIL midreset_no_result: result_valid=1 expected 0");
    end
    set_random();
    load_range(0, NBY - 1, 1);
    run_and_check("after_reset", 0);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 6; t++) begin
      set_random();
      load_range(0, NBY - 1, t[0]);
      run_and_check("random", 0);
    end
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = 8'd0;
    bus.start      = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_negative();
    test_early_start();
    test_load_during_compute();
    test_reset_mid_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
